alu_iter: RTL and testbench

Parametrised, registered successor to the combinational CPU ALU. Single-cycle ops (MOV, ADD, logic, shifts, bit ops, CMP, SEX) complete in one clock. Multiply and new unsigned divide run iteratively over WIDTH cycles, with a START/BUSY/DONE handshake. The block sits in the execute stage; the sequencer stalls on BUSY and writes back on DONE.

---
 rtl/alu_iter_pkg.sv | 40 ++++
 rtl/alu_iter_if.sv | 31 +++
 rtl/alu_iter_muldiv.sv | 81 ++++++++
 rtl/alu_iter.sv | 173 +++++++++++++++++
 tb/tb_alu_iter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_iter_pkg.sv
// Shared opcodes, FSM states and iterative-unit modes for alu_iter.
// Pure declarations; no timing.
// No flow control.
package alu_iter_pkg;

    localparam int ALU_OPX_W = 5;

    typedef logic [ALU_OPX_W-1:0] alu_op_t;

    // 0x00-0x0F keep the legacy ALU encoding; 0x10/0x11 are the new iterative ops
    localparam alu_op_t ALU_OPX_MOV  = 5'h00;
    localparam alu_op_t ALU_OPX_ADD  = 5'h01;
    localparam alu_op_t ALU_OPX_SUB  = 5'h02;
    localparam alu_op_t ALU_OPX_CMP  = 5'h03;
    localparam alu_op_t ALU_OPX_AND  = 5'h04;
    localparam alu_op_t ALU_OPX_OR   = 5'h05;
    localparam alu_op_t ALU_OPX_XOR  = 5'h06;
    localparam alu_op_t ALU_OPX_MUL  = 5'h07;
    localparam alu_op_t ALU_OPX_SL   = 5'h08;
    localparam alu_op_t ALU_OPX_SR   = 5'h09;
    localparam alu_op_t ALU_OPX_SRA  = 5'h0A;
    localparam alu_op_t ALU_OPX_ROT  = 5'h0B;
    localparam alu_op_t ALU_OPX_BIT  = 5'h0C;
    localparam alu_op_t ALU_OPX_SET  = 5'h0D;
    localparam alu_op_t ALU_OPX_CLR  = 5'h0E;
    localparam alu_op_t ALU_OPX_SEX  = 5'h0F;
    localparam alu_op_t ALU_OPX_DIVU = 5'h10;
    localparam alu_op_t ALU_OPX_MULU = 5'h11;

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIN} alu_state_t;

    typedef enum logic [1:0] {MD_MUL, MD_MULU, MD_DIVU} md_mode_t;

    // Divide by zero is resolved in one cycle, so it never enters the iterative path
    function automatic logic is_iter_op(alu_op_t op, logic b_is_zero);
        return (op == ALU_OPX_MUL) || (op == ALU_OPX_MULU) ||
               ((op == ALU_OPX_DIVU) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between the execute-stage sequencer and alu_iter.
// Response flags are valid from a DONE pulse until the next DONE.
// START is only honoured while BUSY is low.
interface alu_iter_if #(parameter int WIDTH = 16);
    import alu_iter_pkg::*;

    logic             start;
    alu_op_t          alux;
    logic [WIDTH-1:0] arga;
    logic [WIDTH-1:0] argb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             sign;
    logic             carry;
    logic             zero;
    logic             parity;
    logic             divz;

    modport master (
        output start, alux, arga, argb,
        input  busy, done, result, result_hi, sign, carry, zero, parity, divz
    );

    modport slave (
        input  start, alux, arga, argb,
        output busy, done, result, result_hi, sign, carry, zero, parity, divz
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per clock.
// WIDTH steps after go; done flags the last step, results are the post-step values.
// go must only be raised while idle; no internal queueing.
module alu_muldiv_iter import alu_iter_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int SHW = $clog2(WIDTH);

    // hi: product high / partial remainder; lo: multiplier / dividend-quotient
    logic             active;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi, lo, mcand;
    logic             is_div, neg;

    logic [WIDTH:0]     sum, shifted, diff;
    logic               ge;
    logic [WIDTH-1:0]   nhi, nlo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // One multiply or divide step computed from the current registers
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, mcand};
        ge      = ~diff[WIDTH];
        if (is_div) begin
            nhi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            nlo = {lo[WIDTH-2:0], ge};
        end else begin
            nhi = sum[WIDTH:1];
            nlo = {sum[0], lo[WIDTH-1:1]};
        end
        prod     = {nhi, nlo};
        prod_fix = neg ? -prod : prod;
    end

    assign done      = active && (cnt == SHW'(WIDTH - 1));
    assign prod_lo   = prod_fix[WIDTH-1:0];
    assign prod_hi   = prod_fix[2*WIDTH-1:WIDTH];
    assign quotient  = nlo;
    assign remainder = nhi;

    // Load magnitudes on go, then step until the counter wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            is_div <= 1'b0;
            neg    <= 1'b0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= '0;
            hi     <= '0;
            is_div <= (mode == MD_DIVU);
            neg    <= (mode == MD_MUL) && (a[WIDTH-1] ^ b[WIDTH-1]);
            lo     <= ((mode == MD_MUL) && a[WIDTH-1]) ? -a : a;
            mcand  <= ((mode == MD_MUL) && b[WIDTH-1]) ? -b : b;
        end else if (active) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + SHW'(1);
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Registered execute-stage ALU: single-cycle ops plus iterative MUL/MULU/DIVU.
// Single-cycle: DONE one clock after START; iterative: DONE WIDTH+1 clocks after START.
// START ignored while BUSY; BUSY is low in the DONE cycle so back-to-back issue works.
module alu_iter import alu_iter_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_iter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    alu_state_t state, state_nxt;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   amt;
    logic             accept, iter_req, single;
    md_mode_t         md_mode;

    logic             md_done;
    logic [WIDTH-1:0] md_prod_lo, md_prod_hi, md_quo, md_rem, md_res, md_hi;
    logic             iter_div;

    logic [WIDTH:0]   add_w, sub_w, shl_w;
    logic [WIDTH-1:0] mask, lowmask;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_carry, sc_divz, sc_ovf_op, sc_ovf, sc_par;

    logic             done_r, sign_r, carry_r, zero_r, parity_r, divz_r;
    logic [WIDTH-1:0] res_r, hi_r;

    assign a        = bus.arga;
    assign b        = bus.argb;
    assign amt      = b[SHW-1:0];
    assign accept   = bus.start && (state != ST_ITER);
    assign iter_req = accept && is_iter_op(bus.alux, b == '0);
    assign single   = accept && !iter_req;
    assign md_mode  = (bus.alux == ALU_OPX_MUL)  ? MD_MUL :
                      (bus.alux == ALU_OPX_MULU) ? MD_MULU : MD_DIVU;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .go        (iter_req),
        .mode      (md_mode),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .prod_lo   (md_prod_lo),
        .prod_hi   (md_prod_hi),
        .quotient  (md_quo),
        .remainder (md_rem)
    );

    assign md_res = iter_div ? md_quo : md_prod_lo;
    assign md_hi  = iter_div ? md_rem : md_prod_hi;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FIN behaves like IDLE for issue, so a START there is not lost
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FIN: state_nxt = iter_req ? ST_ITER : ST_IDLE;
            ST_ITER:         if (md_done) state_nxt = ST_FIN;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    assign add_w   = {1'b0, a} + {1'b0, b};
    assign sub_w   = {1'b0, a} - {1'b0, b};
    assign shl_w   = {1'b0, a} << amt;
    assign mask    = ONE << amt;
    assign lowmask = (mask << 1) - ONE;

    // Single-cycle result, carry/borrow and overflow; unknown opcodes give all ones
    always_comb begin
        sc_res    = '1;
        sc_hi     = '0;
        sc_carry  = 1'b0;
        sc_divz   = 1'b0;
        sc_ovf_op = 1'b0;
        sc_ovf    = 1'b0;
        case (bus.alux)
            ALU_OPX_MOV: sc_res = b;
            ALU_OPX_ADD: begin
                sc_res    = add_w[WIDTH-1:0];
                sc_carry  = add_w[WIDTH];
                sc_ovf_op = 1'b1;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OPX_SUB, ALU_OPX_CMP: begin
                sc_res    = sub_w[WIDTH-1:0];
                sc_carry  = sub_w[WIDTH];
                sc_ovf_op = 1'b1;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OPX_AND: sc_res = a & b;
            ALU_OPX_OR:  sc_res = a | b;
            ALU_OPX_XOR: sc_res = a ^ b;
            ALU_OPX_SL: begin
                sc_res   = shl_w[WIDTH-1:0];
                sc_carry = shl_w[WIDTH];
            end
            ALU_OPX_SR:  sc_res = a >> amt;
            ALU_OPX_SRA: sc_res = $signed(a) >>> amt;
            ALU_OPX_ROT: sc_res = (a >> amt) | (a << (WIDTH - int'(amt)));
            ALU_OPX_BIT: sc_res = a & mask;
            ALU_OPX_SET: sc_res = a | mask;
            ALU_OPX_CLR: sc_res = a & ~mask;
            ALU_OPX_SEX: sc_res = a[amt] ? (a | ~lowmask) : (a & lowmask);
            ALU_OPX_DIVU: begin
                sc_hi   = a;
                sc_divz = 1'b1;
            end
            default: sc_res = '1;
        endcase
        sc_par = sc_ovf_op ? sc_ovf : sc_res[0];
    end

    // Output and flag registers, loaded on a single-cycle accept or the last iterative step
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r   <= 1'b0;
            res_r    <= '0;
            hi_r     <= '0;
            sign_r   <= 1'b0;
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
            parity_r <= 1'b0;
            divz_r   <= 1'b0;
            iter_div <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (iter_req) iter_div <= (bus.alux == ALU_OPX_DIVU);
            if (single) begin
                done_r   <= 1'b1;
                res_r    <= sc_res;
                hi_r     <= sc_hi;
                sign_r   <= sc_res[WIDTH-1];
                zero_r   <= (sc_res == '0);
                carry_r  <= sc_carry;
                parity_r <= sc_par;
                divz_r   <= sc_divz;
            end else if (md_done) begin
                done_r   <= 1'b1;
                res_r    <= md_res;
                hi_r     <= md_hi;
                sign_r   <= md_res[WIDTH-1];
                zero_r   <= (md_res == '0);
                carry_r  <= 1'b0;
                parity_r <= iter_div ? md_res[0] : |md_hi;
                divz_r   <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state == ST_ITER);
    assign bus.done      = done_r;
    assign bus.result    = res_r;
    assign bus.result_hi = hi_r;
    assign bus.sign      = sign_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
    assign bus.parity    = parity_r;
    assign bus.divz      = divz_r;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed cases, randomized ops, reset abort.
// Expected responses come from an arithmetic reference model.
// A monitor pops and compares on every DONE, including its arrival cycle.
module tb_alu_iter;
    import alu_iter_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic [4:0]  flags;   // {sign, carry, zero, parity, divz}
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_iter_if #(.WIDTH(W)) bus();

    alu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic logic ovf16(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference behaviour from plain integer arithmetic
    function automatic exp_t model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          amt, sa, sb2, s;
        longint      q;
        logic [15:0] r, hi;
        logic        c, dz, par_set, par;
        amt = int'(b[3:0]);
        sa  = int'($signed(a));
        sb2 = int'($signed(b));
        r = 16'hFFFF; hi = 16'h0; c = 1'b0; dz = 1'b0; par_set = 1'b0; par = 1'b0;
        case (op)
            ALU_OPX_MOV: r = b;
            ALU_OPX_ADD: begin
                s = int'(a) + int'(b);
                r = s[15:0];
                c = (s > 65535);
                par_set = 1'b1; par = ovf16(sa + sb2);
            end
            ALU_OPX_SUB, ALU_OPX_CMP: begin
                s = int'(a) - int'(b);
                r = s[15:0];
                c = (a < b);
                par_set = 1'b1; par = ovf16(sa - sb2);
            end
            ALU_OPX_AND: r = a & b;
            ALU_OPX_OR:  r = a | b;
            ALU_OPX_XOR: r = a ^ b;
            ALU_OPX_MUL: begin
                q  = longint'(sa) * longint'(sb2);
                r  = q[15:0];
                hi = q[31:16];
                par_set = 1'b1; par = (hi != 16'h0);
            end
            ALU_OPX_MULU: begin
                q  = longint'(a) * longint'(b);
                r  = q[15:0];
                hi = q[31:16];
                par_set = 1'b1; par = (hi != 16'h0);
            end
            ALU_OPX_SL: begin
                r = a << amt;
                c = (amt != 0) ? a[16-amt] : 1'b0;
            end
            ALU_OPX_SR:  r = a >> amt;
            ALU_OPX_SRA: r = 16'($signed(a) >>> amt);
            ALU_OPX_ROT: begin
                r = a;
                repeat (amt) r = {r[0], r[15:1]};
            end
            ALU_OPX_BIT: begin
                r = 16'h0;
                r[amt] = a[amt];
            end
            ALU_OPX_SET: begin
                r = a;
                r[amt] = 1'b1;
            end
            ALU_OPX_CLR: begin
                r = a;
                r[amt] = 1'b0;
            end
            ALU_OPX_SEX: begin
                r = a;
                for (int i = amt + 1; i < 16; i++) r[i] = a[amt];
            end
            ALU_OPX_DIVU: begin
                if (b == 16'h0) begin
                    r = 16'hFFFF; hi = a; dz = 1'b1;
                end else begin
                    r = a / b; hi = a % b;
                end
            end
            default: r = 16'hFFFF;
        endcase
        e.res   = r;
        e.hi    = hi;
        e.flags = {r[15], c, (r == 16'h0), (par_set ? par : r[0]), dz};
        e.cyc   = 0;
        return e;
    endfunction

    function automatic bit takes_iter(input logic [4:0] op, input logic [15:0] b);
        return (op == ALU_OPX_MUL) || (op == ALU_OPX_MULU) || ((op == ALU_OPX_DIVU) && (b != 16'h0));
    endfunction

    // Wait for BUSY low (optionally spraying ignored STARTs), then issue one op
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input bit junk);
        int   guard;
        exp_t e;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 100) begin
            if (junk) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.alux  = 5'($urandom);
                bus.arga  = 16'($urandom);
                bus.argb  = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("busy_timeout", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.alux  = op;
        bus.arga  = a;
        bus.argb  = b;
        e = model(op, a, b);
        e.cyc = cyc + (takes_iter(op, b) ? W + 1 : 1);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Monitor: every DONE must match the oldest expectation, on its expected cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("result", 32'(bus.result), 32'(e.res));
                    chk("result_hi", 32'(bus.result_hi), 32'(e.hi));
                    chk("flags_sczpd", 32'({bus.sign, bus.carry, bus.zero, bus.parity, bus.divz}), 32'(e.flags));
                    chk("busy_in_done", 32'(bus.busy), 32'd0);
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missing_done", 32'(bus.done), 32'd1);
            end
        end
    end

    initial begin
        logic [4:0]  op;
        logic [15:0] ra, rb;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.alux  = '0;
        bus.arga  = '0;
        bus.argb  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_result_hi", 32'(bus.result_hi), 32'd0);
        chk("rst_flags", 32'({bus.sign, bus.carry, bus.zero, bus.parity, bus.divz}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(ALU_OPX_ADD,  16'h7FFF, 16'h0001, 1'b0);
        issue(ALU_OPX_MUL,  16'hFFFD, 16'h0005, 1'b1);
        issue(ALU_OPX_ADD,  16'h0001, 16'h0001, 1'b0);
        issue(ALU_OPX_MULU, 16'hFFFD, 16'h0005, 1'b0);
        issue(ALU_OPX_DIVU, 16'h0064, 16'h0007, 1'b1);
        issue(ALU_OPX_DIVU, 16'h1234, 16'h0000, 1'b0);
        issue(ALU_OPX_ROT,  16'h8001, 16'h0001, 1'b0);
        issue(ALU_OPX_ROT,  16'h8001, 16'h0000, 1'b0);
        issue(ALU_OPX_SL,   16'h8001, 16'h0001, 1'b0);
        issue(ALU_OPX_SL,   16'h8001, 16'h0000, 1'b0);
        issue(ALU_OPX_SEX,  16'h0080, 16'h0007, 1'b0);
        issue(ALU_OPX_SUB,  16'h8000, 16'h0001, 1'b0);
        issue(ALU_OPX_CMP,  16'h0001, 16'h0002, 1'b0);
        issue(ALU_OPX_MUL,  16'h8000, 16'h8000, 1'b0);
        issue(ALU_OPX_DIVU, 16'hFFFF, 16'h0001, 1'b0);
        issue(5'h15,        16'h1111, 16'h2222, 1'b0);

        // Randomized mix, zero divisors and small shift amounts included
        for (int n = 0; n < 400; n++) begin
            op = 5'($urandom_range(0, 19));
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(18, 31));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 16'h0;
            issue(op, ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset mid-DIVU, with a coincident START that must lose to reset
        issue(ALU_OPX_DIVU, 16'hBEEF, 16'h0013, 1'b0);
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.alux  = ALU_OPX_ADD;
        bus.arga  = 16'h0001;
        bus.argb  = 16'h0001;
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_result_hi", 32'(bus.result_hi), 32'd0);
        chk("abort_flags", 32'({bus.sign, bus.carry, bus.zero, bus.parity, bus.divz}), 32'd0);
        repeat (20) @(negedge clk);

        // Unit must be usable again after the abort
        issue(ALU_OPX_MULU, 16'h0100, 16'h0100, 1'b0);
        drain();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
